// File: rtl/seq_det_pkg.sv
// Shared types for the 1011 scan scheduler: scheduler states, detector core
// state encoding, default widths and the detector next-state function.
package seq_det_pkg;

  localparam int DEF_WORD_W = 8;
  localparam int DEF_CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } sched_state_t;

  typedef enum logic [2:0] {
    CORE_Z     = 3'b000,
    CORE_S1    = 3'b001,
    CORE_S10   = 3'b011,
    CORE_S101  = 3'b010,
    CORE_S1011 = 3'b110
  } core_state_t;

  // Overlapping "1011" recogniser; after a match the trailing "1" seeds S1.
  function automatic core_state_t core_next(input core_state_t cur, input logic b);
    core_state_t nxt;
    case (cur)
      CORE_Z:     nxt = b ? CORE_S1    : CORE_Z;
      CORE_S1:    nxt = b ? CORE_S1    : CORE_S10;
      CORE_S10:   nxt = b ? CORE_S101  : CORE_Z;
      CORE_S101:  nxt = b ? CORE_S1011 : CORE_S10;
      CORE_S1011: nxt = b ? CORE_S1    : CORE_S10;
      default:    nxt = CORE_Z;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/seq1011_moore_core.sv
// Serial "1011" Moore detector with synchronous clear and bit enable.
// detect_out is registered alongside the state so it is glitch-free.
module seq1011_moore_core
  import seq_det_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic en,
  input  logic bit_in,
  output logic detect_out
);

  core_state_t state;
  core_state_t state_next;

  assign state_next = core_next(state, bit_in);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= CORE_Z;
      detect_out <= 1'b0;
    end else if (clear) begin
      state      <= CORE_Z;
      detect_out <= 1'b0;
    end else if (en) begin
      state      <= state_next;
      detect_out <= (state_next == CORE_S1011);
    end
  end

endmodule

// File: rtl/seq1011_scan_sched.sv
// Round-robin scheduler feeding words from two requesters MSB-first through
// one shared 1011 detector core and returning the per-word match count.
module seq1011_scan_sched
  import seq_det_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [WORD_W-1:0] req0_word,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [WORD_W-1:0] req1_word,
  output logic              req1_ready,
  output logic              busy,
  output logic              done,
  output logic              done_id,
  output logic [CNT_W-1:0]  match_count,
  output logic              bit_out,
  output logic              detect_out
);

  localparam int                IDX_W    = $clog2(WORD_W);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  sched_state_t      state;
  logic              last_served;
  logic [WORD_W-1:0] shift_reg;
  logic [IDX_W-1:0]  bit_idx;
  logic              grant0;
  logic              grant1;
  logic              accept;
  logic              core_en;
  logic [WORD_W-1:0] word_sel;

  // last_served==1 means req1 was served last, so req0 wins a contest.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (req0_valid && req1_valid) begin
      grant0 = last_served;
      grant1 = ~last_served;
    end else begin
      grant0 = req0_valid;
      grant1 = req1_valid;
    end
  end

  assign req0_ready = (state == IDLE) & grant0;
  assign req1_ready = (state == IDLE) & grant1;
  assign accept     = req0_ready | req1_ready;
  assign word_sel   = req1_ready ? req1_word : req0_word;
  assign core_en    = (state == SHIFT);

  // The MSB of the shift register is the presented bit; it drains to zero
  // by FLUSH, which keeps bit_out a plain flop output.
  assign bit_out = shift_reg[WORD_W-1];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      last_served <= 1'b1;
      done        <= 1'b0;
      done_id     <= 1'b0;
      match_count <= '0;
      busy        <= 1'b0;
      shift_reg   <= '0;
      bit_idx     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            shift_reg   <= word_sel;
            done_id     <= grant1;
            last_served <= grant1;
            match_count <= '0;
            bit_idx     <= '0;
            busy        <= 1'b1;
            state       <= SHIFT;
          end
        end
        SHIFT: begin
          shift_reg <= {shift_reg[WORD_W-2:0], 1'b0};
          if (detect_out && match_count != CNT_MAX)
            match_count <= match_count + 1'b1;
          if (bit_idx == LAST_IDX)
            state <= FLUSH;
          else
            bit_idx <= bit_idx + 1'b1;
        end
        FLUSH: begin
          // Core output for the final bit only becomes visible here.
          if (detect_out && match_count != CNT_MAX)
            match_count <= match_count + 1'b1;
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  seq1011_moore_core u_core (
    .clock      (clock),
    .reset      (reset),
    .clear      (accept),
    .en         (core_en),
    .bit_in     (bit_out),
    .detect_out (detect_out)
  );

endmodule

// File: doc/seq1011_scan_sched.md
# seq1011_scan_sched

Round-robin scheduler sharing one serial "1011" Moore detector between two word-level requesters. Accepts an 8-bit word from the granted requester and shifts it MSB-first through a dedicated detector core, clearing the core first. Counts overlapping "1011" matches and returns the count with a one-cycle done pulse tagged with the requester id. Sits between parallel producers and the serial pattern-detection datapath.

## Interface
- WORD_W, 8, bits per scanned word (≥4)
- CNT_W, 4, match counter width; counter saturates at all-ones
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- req0_valid  in  1  requester 0 has a word
- req0_word  in  WORD_W  requester 0 word, stable while valid
- req0_ready  out  1  requester 0 word accepted this cycle
- req1_valid  in  1  requester 1 has a word
- req1_word  in  WORD_W  requester 1 word
- req1_ready  out  1  requester 1 word accepted this cycle
- busy  out  1  scan in progress (SHIFT/FLUSH/DONE)
- done  out  1  one-cycle pulse, result valid
- done_id  out  1  requester id of the finished scan
- match_count  out  CNT_W  matches in the last scanned word
- bit_out  out  1  serial bit currently presented to the core
- detect_out  out  1  core Moore output (debug)

## Operation
- Scheduler FSM: IDLE → SHIFT → FLUSH → DONE → IDLE.
- IDLE: grant computed combinationally. One valid → that one granted. Both valid → requester not served last. Last-served pointer resets to 1 (req0 wins first contest).
- reqN_ready = (state==IDLE) & grantN. Transfer when valid & ready. Valid must hold until ready; dropping valid before ready is legal and cancels the request.
- On accept: latch word into shift register, latch id into done_id, clear match_count, assert core sync clear, update pointer, enter SHIFT with bit index 0.
- SHIFT: bit_out = word[WORD_W-1-k] in bit cycle k. Core samples bit_out each edge. Exit to FLUSH after bit WORD_W-1.
- FLUSH: one cycle. Core output for the final bit is visible here.
- In SHIFT and FLUSH, match_count increments on each edge where detect_out=1. It saturates at 2^CNT_W-1.
- DONE: done=1 for exactly one cycle. match_count and done_id are valid here and hold until the next accept.
- Core states: Z, S1, S10, S101, S1011. Output is 1 only in S1011.
  - Z: 1→S1, 0→Z
  - S1: 1→S1, 0→S10
  - S10: 1→S101, 0→Z
  - S101: 1→S1011, 0→S10
  - S1011: 1→S1, 0→S10
  - Sync clear → Z. Clear has priority over input.
- Reset values: state IDLE, pointer 1, done 0, done_id 0, match_count 0, busy 0, bit_out 0, shift register 0, core Z (detect_out 0). Both ready outputs are then purely a function of valid.
- Reset mid-scan: immediate return to IDLE. The word is dropped, no done pulse, pointer returns to 1.
- Requests arriving while busy wait. No accept occurs in SHIFT, FLUSH or DONE.

## Timing
- Accept edge = t0.
- SHIFT bit k occupies the cycle after edge t0+k.
- FLUSH follows edge t0+WORD_W. DONE follows edge t0+WORD_W+1. IDLE follows edge t0+WORD_W+2.
- done pulse: WORD_W+1 edges after accept.
- Minimum accept-to-accept period: WORD_W+3 cycles (11 at default).
- All outputs except reqN_ready are registered.

## Structure
- Shared package seq_det_pkg holds:
  - scheduler state enum (IDLE, SHIFT, FLUSH, DONE)
  - core state encoding: Z=000, S1=001, S10=011, S101=010, S1011=110
  - default WORD_W/CNT_W constants
- One sub-module: seq1011_moore_core. Ports: clock, reset, clear, en, bit_in, detect_out. The core updates only when en=1; the scheduler drives en during SHIFT.
- Round-robin pointer, counter and shift register stay in the top level.

## Test plan
- req0 word 8'b1011_0110 after reset → req0_ready 1 for one cycle; done 9 edges later; done_id 0; match_count 2.
- req1 word 8'b1111_1011 → match_count 1; increment occurs in FLUSH (S1 self-loop). Word 8'h00 → match_count 0.
- Both valid from reset, words 8'b1011_1011 and 8'hFF → req0 served first (count 2), then req1 (count 0, done_id 1). req1_ready stays 0 while busy.
- req0 held valid continuously, req1 idle → accepts exactly every 11 cycles. match_count holds between done pulses.
- Reset pulsed during SHIFT bit 4 → busy/done/match_count 0 immediately, no done pulse. The next contest grants req0.
- req0 drops valid before grant while req1 is valid → req1 granted, no spurious req0 transfer.
